// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: one outstanding memory request, variable-latency responses,
// and a DEPTH-entry {pc, instruction} queue presented to ID with valid/ready.
module riscv_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             inst_ce_o,
    output logic [XLEN-1:0]  inst_addr_o,
    input  logic [XLEN-1:0]  inst_i,
    input  logic             inst_valid_i,
    input  logic             branch_i,
    input  logic [XLEN-1:0]  branch_addr_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [XLEN-1:0]  id_inst_o,
    output logic [XLEN-1:0]  id_pc_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      OCC_W     = $clog2(DEPTH + 1) + 1;
    localparam logic [OCC_W-1:0] DEPTH_V   = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0]  ALIGN_M   = ~(XLEN'(3));
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  pend_pc_r;
    logic             pend_r;
    logic             discard_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [OCC_W-1:0] count_r;
    logic [XLEN-1:0]  pc_mem_r   [DEPTH];
    logic [XLEN-1:0]  inst_mem_r [DEPTH];
    logic [CNT_W-1:0] flush_cnt_r;

    logic             resp_s;
    logic             room_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic [OCC_W-1:0] occ_s;

    // Per-cycle handshake decode; the outstanding request already owns a queue slot.
    always_comb begin
        resp_s  = inst_valid_i & pend_r;
        occ_s   = count_r + OCC_W'(pend_r);
        room_s  = (occ_s < DEPTH_V);
        issue_s = ~rst & ~branch_i & (~pend_r | resp_s) & room_s;
        push_s  = resp_s & ~discard_r & ~branch_i;
        pop_s   = (count_r != OCC_ZERO) & id_ready_i & ~branch_i;
    end

    // Output view of the state, held at reset values while rst is high.
    always_comb begin
        inst_ce_o   = issue_s;
        flush_cnt_o = flush_cnt_r;
        if (rst) begin
            inst_addr_o = RESET_PC;
            id_valid_o  = 1'b0;
            id_inst_o   = XLEN_ZERO;
            id_pc_o     = XLEN_ZERO;
        end else begin
            inst_addr_o = fetch_pc_r;
            id_valid_o  = (count_r != OCC_ZERO);
            id_inst_o   = inst_mem_r[rd_ptr_r];
            id_pc_o     = pc_mem_r[rd_ptr_r];
        end
    end

    // Fetch PC, outstanding-request and in-flight-discard tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            pend_pc_r  <= XLEN_ZERO;
            pend_r     <= 1'b0;
            discard_r  <= 1'b0;
        end else if (branch_i) begin
            fetch_pc_r <= branch_addr_i & ALIGN_M;
            if (pend_r & ~inst_valid_i) begin
                // Word still in flight: keep pend so it is swallowed when it lands.
                discard_r <= 1'b1;
            end else if (resp_s) begin
                pend_r    <= 1'b0;
                discard_r <= 1'b0;
            end
        end else begin
            if (issue_s) begin
                pend_r     <= 1'b1;
                pend_pc_r  <= fetch_pc_r;
                fetch_pc_r <= fetch_pc_r + PC_STEP;
            end else if (resp_s) begin
                pend_r <= 1'b0;
            end
            if (resp_s) begin
                discard_r <= 1'b0;
            end
        end
    end

    // Queue pointers, occupancy and storage; a redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= OCC_ZERO;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= XLEN_ZERO;
                inst_mem_r[i] <= XLEN_ZERO;
            end
        end else if (branch_i) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= OCC_ZERO;
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]   <= pend_pc_r;
                inst_mem_r[wr_ptr_r] <= inst_i;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + OCC_ONE;
                2'b01:   count_r <= count_r - OCC_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_r <= CNT_ZERO;
        end else if (branch_i && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Self-checking bench for riscv_fetch_queue: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model with a latency-driven memory.
module tb_riscv_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned FCNT_MAX = 65535;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        inst_ce_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i = 32'h0;
    logic        inst_valid_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic [15:0] flush_cnt_o;

    logic        rst2 = 1'b1;
    logic        ce2;
    logic [31:0] addr2;
    logic [31:0] inst2 = 32'h0;
    logic        valid2 = 1'b0;
    logic        br2 = 1'b0;
    logic [31:0] baddr2 = 32'h0;
    logic        idv2;
    logic        ready2 = 1'b0;
    logic [31:0] idinst2;
    logic [31:0] idpc2;
    logic [1:0]  fcnt2;

    riscv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .inst_ce_o(inst_ce_o), .inst_addr_o(inst_addr_o),
        .inst_i(inst_i), .inst_valid_i(inst_valid_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_inst_o(id_inst_o), .id_pc_o(id_pc_o), .flush_cnt_o(flush_cnt_o)
    );

    riscv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst2), .inst_ce_o(ce2), .inst_addr_o(addr2),
        .inst_i(inst2), .inst_valid_i(valid2), .branch_i(br2),
        .branch_addr_i(baddr2), .id_valid_o(idv2), .id_ready_i(ready2),
        .id_inst_o(idinst2), .id_pc_o(idpc2), .flush_cnt_o(fcnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural fetch state plus a plain queue of {pc, inst}.
    logic [31:0] m_fetch   = RESET_PC;
    logic [31:0] m_pend_pc = 32'h0;
    logic        m_pend    = 1'b0;
    logic        m_discard = 1'b0;
    logic [63:0] m_q[$];
    int unsigned m_fcnt    = 0;

    // Instruction memory: one request at a time, answered after a configurable latency.
    logic        mem_pend  = 1'b0;
    int          mem_wait  = 0;
    logic [31:0] mem_addr  = 32'h0;
    int          fixed_lat = 1;
    bit          spur_en   = 1'b0;

    typedef struct packed {
        logic        rst;
        logic        ready;
        logic        br;
        logic [31:0] baddr;
        logic        ce;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] idpc;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle on the main DUT: drive inputs, compare against the model, advance the model.
    task automatic step(input logic s_rst, input logic s_ready, input logic s_br, input logic [31:0] s_baddr);
        logic        m_resp;
        logic        m_ce;
        logic        do_pop;
        logic        mem_hit;
        logic [63:0] head;
        int          lat;
        @(negedge clk);
        rst           = s_rst;
        id_ready_i    = s_ready;
        branch_i      = s_br;
        branch_addr_i = s_baddr;
        mem_hit       = 1'b0;
        if (mem_pend) begin
            if (mem_wait == 0) mem_hit = 1'b1;
            else mem_wait = mem_wait - 1;
        end
        if (mem_hit) begin
            inst_valid_i = 1'b1;
            inst_i       = mem_word(mem_addr);
        end else if (!mem_pend && spur_en && ($urandom_range(0, 7) == 0)) begin
            inst_valid_i = 1'b1;
            inst_i       = $urandom;
        end else begin
            inst_valid_i = 1'b0;
            inst_i       = $urandom;
        end
        #1;
        m_resp = inst_valid_i & m_pend;
        m_ce   = !s_rst && !s_br && (!m_pend || m_resp) && ((m_q.size() + int'(m_pend)) < DEPTH);
        check("inst_ce", {31'h0, inst_ce_o}, {31'h0, m_ce});
        check("inst_addr", inst_addr_o, s_rst ? RESET_PC : m_fetch);
        check("id_valid", {31'h0, id_valid_o}, {31'h0, (!s_rst && m_q.size() != 0)});
        if (s_rst) begin
            check("id_pc_rst", id_pc_o, 32'h0);
            check("id_inst_rst", id_inst_o, 32'h0);
        end else begin
            check("flush_cnt", {16'h0, flush_cnt_o}, m_fcnt);
            if (m_q.size() != 0) begin
                head = m_q[0];
                check("id_pc", id_pc_o, head[63:32]);
                check("id_inst", id_inst_o, head[31:0]);
            end
        end
        if (mem_hit) mem_pend = 1'b0;
        if (m_ce) begin
            lat      = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
            mem_pend = 1'b1;
            mem_addr = m_fetch;
            mem_wait = lat - 1;
        end
        if (s_rst) begin
            m_fetch   = RESET_PC;
            m_pend    = 1'b0;
            m_discard = 1'b0;
            m_fcnt    = 0;
            m_q.delete();
        end else if (s_br) begin
            m_q.delete();
            m_fetch = {s_baddr[31:2], 2'b00};
            if (m_pend && !inst_valid_i) begin
                m_discard = 1'b1;
            end else if (m_resp) begin
                m_pend    = 1'b0;
                m_discard = 1'b0;
            end
            if (m_fcnt < FCNT_MAX) m_fcnt++;
        end else begin
            do_pop = (m_q.size() != 0) && s_ready;
            if (do_pop) void'(m_q.pop_front());
            if (m_resp) begin
                if (m_discard) m_discard = 1'b0;
                else m_q.push_back({m_pend_pc, inst_i});
            end
            if (m_ce) begin
                m_pend    = 1'b1;
                m_pend_pc = m_fetch;
                m_fetch   = m_fetch + 32'd4;
            end else if (m_resp) begin
                m_pend = 1'b0;
            end
        end
    endtask

    initial begin
        int  k;
        bit  seen;
        int  rdy_pct;

        // {rst, ready, br, baddr, exp ce, exp addr, exp id_valid, exp id_pc}
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h4};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h4};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 1'b1, 32'h8};

        // Streaming at one per cycle, then fill-to-full under backpressure (1-cycle memory).
        fixed_lat = 1;
        spur_en   = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].rst, vecs[i].ready, vecs[i].br, vecs[i].baddr);
            check($sformatf("tbl%0d_ce", i), {31'h0, inst_ce_o}, {31'h0, vecs[i].ce});
            check($sformatf("tbl%0d_addr", i), inst_addr_o, vecs[i].addr);
            check($sformatf("tbl%0d_idv", i), {31'h0, id_valid_o}, {31'h0, vecs[i].idv});
            if (vecs[i].idv) check($sformatf("tbl%0d_idpc", i), id_pc_o, vecs[i].idpc);
        end

        // Redirect to 0x103 while the 0x8 fetch is in flight on a 3-cycle memory.
        fixed_lat = 3;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 10) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            k++;
            if (inst_ce_o) seen = 1'b1;
        end
        check("br_issue_seen", {31'h0, seen}, 32'h1);
        check("br_issue_wait", k, 32'd2);
        check("br_issue_addr", inst_addr_o, 32'h0000_0100);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 10) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            k++;
            if (id_valid_o) seen = 1'b1;
        end
        check("br_head_seen", {31'h0, seen}, 32'h1);
        check("br_head_pc", id_pc_o, 32'h0000_0100);
        check("br_flush_cnt", {16'h0, flush_cnt_o}, 32'd1);

        // Redirect in the same cycle as a push and a pop.
        fixed_lat = 1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("pp_br_idv", {31'h0, id_valid_o}, 32'h0);
        check("pp_br_flush", {16'h0, flush_cnt_o}, 32'd1);
        check("pp_br_ce", {31'h0, inst_ce_o}, 32'h1);
        check("pp_br_addr", inst_addr_o, 32'h0000_0200);

        // Reset with a request outstanding; the late response must be ignored.
        fixed_lat = 2;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("rst_stale_ce", {31'h0, inst_ce_o}, 32'h1);
        check("rst_stale_addr", inst_addr_o, RESET_PC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("rst_stale_idv", {31'h0, id_valid_o}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("rst_first_idv", {31'h0, id_valid_o}, 32'h1);
        check("rst_first_pc", id_pc_o, RESET_PC);

        // Randomized traffic: random latency, redirects, resets, spurious strobes, ready duty.
        fixed_lat = 0;
        spur_en   = 1'b1;
        rdy_pct   = 100;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 2000; c++) begin
            if (c % 150 == 0) rdy_pct = $urandom_range(10, 100);
            step($urandom_range(0, 199) == 0, $urandom_range(1, 100) <= rdy_pct,
                 $urandom_range(0, 11) == 0, $urandom);
        end

        // Second instance: PC wrap from 0xFFFFFFFC and 2-bit flush counter saturation.
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2   = 1'b0;
        ready2 = 1'b1;
        #1;
        check("wrap_ce0", {31'h0, ce2}, 32'h1);
        check("wrap_addr0", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        valid2 = 1'b1;
        inst2  = 32'hCAFE_0001;
        #1;
        check("wrap_ce1", {31'h0, ce2}, 32'h1);
        check("wrap_addr1", addr2, 32'h0000_0000);
        @(negedge clk);
        valid2 = 1'b0;
        #1;
        check("wrap_idv", {31'h0, idv2}, 32'h1);
        check("wrap_idpc", idpc2, 32'hFFFF_FFFC);
        check("wrap_idinst", idinst2, 32'hCAFE_0001);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            br2    = 1'b1;
            baddr2 = 32'h40 * b;
            #1;
            check($sformatf("sat_cnt%0d", b), {30'h0, fcnt2}, (b < 3) ? b : 3);
        end
        @(negedge clk);
        br2 = 1'b0;
        #1;
        check("sat_cnt_final", {30'h0, fcnt2}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
